sdcard_spi_master: RTL

//  Byte-wide SPI mode-0 master for the SD card slot; replaces bit-banging of sdcard_sck/sdcard_mosi via PORTB.

---
 rtl/sdcard_spi_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sdcard_spi_master.sv
// Byte-wide SPI mode-0 (CPOL=0, CPHA=0) master for the SD card slot, register-mapped on the CPU peripheral bus.
// Latency: a byte transfer takes 16*(DIV+1) clk cycles from the DATA write to DONE; register reads are combinational.
// Backpressure: none; a DATA write while BUSY is dropped and sets sticky OVR. Optional SDCARD_SPI_CS_EN adds sdcard_cs via STAT bit7.
module sdcard_spi_master #(
    parameter logic [7:0] DIV_RESET = 8'd63
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    input  logic [1:0]  addr,
    input  logic        cs,
    input  logic        oe,
    input  logic [3:0]  wstrb,
    output logic        sdcard_sck,
    output logic        sdcard_mosi,
    input  logic        sdcard_miso
`ifdef SDCARD_SPI_CS_EN
    ,
    output logic        sdcard_cs
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0] state;
    logic [7:0] hcnt;
    logic [2:0] bcnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [7:0] rx_data;
    logic [7:0] div;
    logic       done;
    logic       ovr;
    logic       busy;
    logic       csn_bit;

    logic wr_data, wr_stat, wr_div, rd_data, done_set;
    logic unused_bits;

    assign unused_bits = ^{data_in[31:8], wstrb[3:1]};

    assign wr_data  = cs && wstrb[0] && (addr == 2'd0);
    assign wr_stat  = cs && wstrb[0] && (addr == 2'd1);
    assign wr_div   = cs && wstrb[0] && (addr == 2'd2);
    assign rd_data  = cs && oe && (addr == 2'd0);
    assign busy     = (state != ST_IDLE);
    // Last falling SCK edge of the byte: this is where rx_data is latched and DONE rises.
    assign done_set = (state == ST_HIGH) && (hcnt == 8'd0) && (bcnt == 3'd0);

    // Shift engine: half-period counter paces SCK, bit counter walks MSB-first through the byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hcnt        <= 8'd0;
            bcnt        <= 3'd0;
            tx_sh       <= 8'd0;
            rx_sh       <= 8'd0;
            rx_data     <= 8'd0;
            sdcard_sck  <= 1'b0;
            sdcard_mosi <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_data) begin
                        tx_sh       <= data_in[7:0];
                        sdcard_mosi <= data_in[7];
                        bcnt        <= 3'd7;
                        hcnt        <= div;
                        state       <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (hcnt != 8'd0) begin
                        hcnt <= hcnt - 8'd1;
                    end else begin
                        sdcard_sck <= 1'b1;
                        rx_sh      <= {rx_sh[6:0], sdcard_miso};
                        hcnt       <= div;
                        state      <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (hcnt != 8'd0) begin
                        hcnt <= hcnt - 8'd1;
                    end else begin
                        sdcard_sck <= 1'b0;
                        if (bcnt == 3'd0) begin
                            rx_data     <= rx_sh;
                            sdcard_mosi <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            sdcard_mosi <= tx_sh[6];
                            tx_sh       <= {tx_sh[6:0], 1'b0};
                            bcnt        <= bcnt - 3'd1;
                            hcnt        <= div;
                            state       <= ST_LOW;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status and config: DONE set beats the clearing DATA read; OVR is sticky until software clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            ovr     <= 1'b0;
            div     <= DIV_RESET;
            csn_bit <= 1'b1;
        end else begin
            if (done_set) begin
                done <= 1'b1;
            end else if (rd_data) begin
                done <= 1'b0;
            end
            if (wr_data && busy) begin
                ovr <= 1'b1;
            end else if (wr_stat && data_in[2]) begin
                ovr <= 1'b0;
            end
            if (wr_div) begin
                div <= data_in[7:0];
            end
            if (wr_stat) begin
                csn_bit <= data_in[7];
            end
        end
    end

`ifdef SDCARD_SPI_CS_EN
    assign sdcard_cs = csn_bit;
    logic stat_b7;
    assign stat_b7 = csn_bit;
`else
    logic stat_b7;
    logic unused_csn;
    assign stat_b7    = 1'b0;
    assign unused_csn = csn_bit;
`endif

    // Read mux: combinational, forced to zero unless the block is selected for reading.
    always_comb begin
        data_out = 32'd0;
        if (cs && oe && !rst) begin
            case (addr)
                2'd0:    data_out = {24'd0, rx_data};
                2'd1:    data_out = {24'd0, stat_b7, 4'd0, ovr, done, busy};
                2'd2:    data_out = {24'd0, div};
                default: data_out = 32'd0;
            endcase
        end
    end

endmodule
